// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the mem_loader boot loader.
// Optional checksum trailer is enabled with MEM_LOADER_CHECKSUM_EN.
package loader_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned COUNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_COUNT,
        ST_DATA,
        ST_CSUM,
        ST_RUN,
        ST_ERROR
    } state_e;

    localparam logic [BYTE_W-1:0] CMD_IMEM = 8'h01;
    localparam logic [BYTE_W-1:0] CMD_DMEM = 8'h02;
    localparam logic [BYTE_W-1:0] CMD_RUN  = 8'h03;

    // True for the states that still take stream bytes.
    function automatic logic state_accepts(input state_e st);
        return (st != ST_RUN) && (st != ST_ERROR);
    endfunction

endpackage

// File: rtl/mem_loader_byte_packer.sv
// byte_packer: shifts stream bytes into a big-endian word and flags every 4th byte.
// clear_i realigns the byte count to a word boundary.
module byte_packer
    import loader_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              shift_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [1:0]        count_o,
    output logic [WORD_W-1:0] word_next_c,
    output logic              word_valid_c
);

    logic [WORD_W-1:0] word_q;
    logic [1:0]        count_q;

    // Earliest byte ends up in the MSB once four bytes are in.
    assign word_next_c  = {word_q[WORD_W-BYTE_W-1:0], byte_i};
    assign word_valid_c = shift_i && (count_q == 2'd3);
    assign count_o      = count_q;

    always_ff @(posedge clock) begin
        if (reset || clear_i) begin
            word_q  <= '0;
            count_q <= 2'd0;
        end else if (shift_i) begin
            word_q  <= word_next_c;
            count_q <= count_q + 2'd1;
        end
    end

endmodule

// File: rtl/mem_loader.sv
// mem_loader: byte-stream boot loader writing IMEM/DMEM and releasing the core on RUN.
// Define MEM_LOADER_CHECKSUM_EN to require an XOR checksum byte after each non-empty block.
module mem_loader
    import loader_pkg::*;
#(
    parameter int unsigned IMEM_WORDS = 1024,
    parameter int unsigned DMEM_BYTES = 4096
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        imem_we,
    output logic        dmem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);

    localparam logic [WORD_W:0] IMEM_LIMIT = 33'(IMEM_WORDS) << 2;
    localparam logic [WORD_W:0] DMEM_LIMIT = 33'(DMEM_BYTES);

    state_e state_q, state_d;

    logic [WORD_W-1:0]  addr_q, addr_d;
    logic [COUNT_W-1:0] left_q, left_d;
    logic               imem_sel_q, imem_sel_d;
    logic               imem_we_q, imem_we_d;
    logic               dmem_we_q, dmem_we_d;
    logic [WORD_W-1:0]  mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic               in_ready_q, in_ready_d;
    logic               cpu_reset_q, cpu_reset_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
`ifdef MEM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0]  csum_q, csum_d;
`endif

    logic               accept_c;
    logic               out_of_range_c;
    logic               pk_clear_c;
    logic               pk_shift_c;
    logic [1:0]         pk_count;
    logic [WORD_W-1:0]  pk_word_next_c;
    logic               pk_word_valid_c;

    byte_packer u_packer (
        .clock        (clock),
        .reset        (reset),
        .clear_i      (pk_clear_c),
        .shift_i      (pk_shift_c),
        .byte_i       (in_data),
        .count_o      (pk_count),
        .word_next_c  (pk_word_next_c),
        .word_valid_c (pk_word_valid_c)
    );

    assign accept_c = in_valid && in_ready_q;

    // Range check on the whole word; 33-bit math keeps addresses near 2^32 from wrapping into range.
    assign out_of_range_c = imem_sel_q ? ({1'b0, addr_q} >= IMEM_LIMIT)
                                       : (({1'b0, addr_q} + 33'd3) >= DMEM_LIMIT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        left_d      = left_q;
        imem_sel_d  = imem_sel_q;
        imem_we_d   = 1'b0;
        dmem_we_d   = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        pk_clear_c  = 1'b0;
        pk_shift_c  = 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
        csum_d      = csum_q;
`endif

        case (state_q)
            ST_IDLE: begin
                pk_clear_c = 1'b1;
                if (accept_c) begin
                    case (in_data)
                        CMD_IMEM: begin
                            state_d    = ST_ADDR;
                            imem_sel_d = 1'b1;
                        end
                        CMD_DMEM: begin
                            state_d    = ST_ADDR;
                            imem_sel_d = 1'b0;
                        end
                        CMD_RUN: state_d = ST_RUN;
                        default: state_d = ST_ERROR;
                    endcase
                end
            end
            ST_ADDR: begin
                pk_shift_c = accept_c;
                if (pk_word_valid_c) begin
                    addr_d  = pk_word_next_c;
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                pk_shift_c = accept_c;
                // Second count byte: realign the packer so data starts on a word boundary.
                if (accept_c && (pk_count == 2'd1)) begin
                    pk_clear_c = 1'b1;
                    left_d     = pk_word_next_c[COUNT_W-1:0];
`ifdef MEM_LOADER_CHECKSUM_EN
                    csum_d     = '0;
`endif
                    if (addr_q[1:0] != 2'b00) begin
                        state_d = ST_ERROR;
                    end else if (pk_word_next_c[COUNT_W-1:0] == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                pk_shift_c = accept_c;
`ifdef MEM_LOADER_CHECKSUM_EN
                if (accept_c) begin
                    csum_d = csum_q ^ in_data;
                end
`endif
                if (pk_word_valid_c) begin
                    if (out_of_range_c) begin
                        state_d = ST_ERROR;
                    end else begin
                        imem_we_d   = imem_sel_q;
                        dmem_we_d   = !imem_sel_q;
                        mem_addr_d  = addr_q;
                        mem_wdata_d = pk_word_next_c;
                        addr_d      = addr_q + 32'd4;
                        left_d      = left_q - 16'd1;
                        if (left_q == 16'd1) begin
`ifdef MEM_LOADER_CHECKSUM_EN
                            state_d = ST_CSUM;
`else
                            state_d = ST_IDLE;
`endif
                        end
                    end
                end
            end
`ifdef MEM_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (accept_c) begin
                    state_d = (in_data == csum_q) ? ST_IDLE : ST_ERROR;
                end
            end
`endif
            ST_RUN:   state_d = ST_RUN;
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_ERROR;
        endcase
    end

    // Status outputs are registered copies of the next state so they track it with no lag.
    assign in_ready_d  = state_accepts(state_d);
    assign cpu_reset_d = (state_d != ST_RUN);
    assign done_d      = (state_d == ST_RUN);
    assign error_d     = (state_d == ST_ERROR);

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q      <= '0;
            left_q      <= '0;
            imem_sel_q  <= 1'b0;
            imem_we_q   <= 1'b0;
            dmem_we_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            in_ready_q  <= 1'b1;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            addr_q      <= addr_d;
            left_q      <= left_d;
            imem_sel_q  <= imem_sel_d;
            imem_we_q   <= imem_we_d;
            dmem_we_q   <= dmem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            in_ready_q  <= in_ready_d;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
            error_q     <= error_d;
`ifdef MEM_LOADER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign imem_we   = imem_we_q;
    assign dmem_we   = dmem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_reset = cpu_reset_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: doc/mem_loader.md
# mem_loader

Synthesizable boot loader that sits directly upstream of the `singlecycle` core. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words. It writes those words into the instruction memory and data memory write ports, and holds the core in reset until a RUN command arrives. It replaces simulation-only `$readmemh` preloading with a path usable on hardware and in system-level benches.

## Interface
- `IMEM_WORDS`, default 1024: IMEM depth in words; IMEM writes with byte address ≥ 4·IMEM_WORDS raise `error`.
- `DMEM_BYTES`, default 4096: DMEM size in bytes; DMEM writes whose last byte falls outside it raise `error`.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `in_data` in 8: stream byte.
- `in_valid` in 1: byte present.
- `in_ready` out 1: loader accepts the byte; a transfer occurs when `in_valid && in_ready`.
- `imem_we` out 1: IMEM word write strobe, one cycle per word.
- `dmem_we` out 1: DMEM word write strobe, one cycle per word (size = word).
- `mem_addr` out 32: byte address for the current write.
- `mem_wdata` out 32: word being written; the first stream byte is the MSB.
- `cpu_reset` out 1: drives the core's reset input; 1 holds the core in reset.
- `done` out 1: RUN reached.
- `error` out 1: sticky protocol or range error.

## Operation
- Commands are taken in IDLE:
  - `0x01` loads IMEM.
  - `0x02` loads DMEM.
  - `0x03` selects RUN.
  - Any other byte selects ERROR.
- A load command is followed by:
  - a 4-byte start byte address, MSB first;
  - a 2-byte word count N, MSB first;
  - N×4 data bytes;
  - a checksum byte, only when the checksum feature is compiled in (see Configuration).
- State machine:
  - IDLE →(01/02) ADDR →(4 bytes) COUNT →(2 bytes) DATA, or → IDLE if N=0.
  - DATA →(after 4·N bytes) CSUM if checksum is enabled, otherwise IDLE.
  - CSUM → IDLE on match, → ERROR on mismatch.
  - IDLE →(03) RUN.
  - RUN and ERROR are terminal until `reset`.
- A low bit-pair on the address (addr[1:0] ≠ 0) selects ERROR at the end of COUNT, and no writes occur.
- The write address starts at the given address and increments by 4 per word, wrapping modulo 2^32.
  - An out-of-range word is not written (strobe suppressed) and selects ERROR.
- `in_ready` = 1 in IDLE, ADDR, COUNT, DATA and CSUM; 0 in RUN and ERROR.
- Multiple load blocks may precede RUN. A later block overwrites earlier words.
- `cpu_reset` = 1 in every state except RUN. ERROR keeps the core in reset.

## Timing
- Reset values:
  - state = IDLE
  - `in_ready` = 1
  - `imem_we` = `dmem_we` = 0
  - `mem_addr` = `mem_wdata` = 0
  - `cpu_reset` = 1
  - `done` = 0
  - `error` = 0
- The byte accepted in cycle k is reflected in state in cycle k+1.
- When the 4th byte of a word is accepted in cycle k:
  - `imem_we` or `dmem_we` is 1 in cycle k+1 only;
  - `mem_addr` and `mem_wdata` are registered and stable in cycle k+1.
- If `0x03` is accepted in cycle k, then `cpu_reset` = 0 and `done` = 1 from cycle k+1 onward.
- `error` rises in the cycle after the offending byte is accepted and holds until `reset`.
- Gaps in `in_valid` stall the FSM with no state change, and no strobe is generated.
- `reset` asserted mid-block:
  - abandons the partial word (no write);
  - returns all outputs to their reset values the next cycle, including `cpu_reset` = 1 if the core was running.

## Configuration
- `MEM_LOADER_CHECKSUM_EN` defined:
  - each load block ends with a checksum byte equal to the XOR of all 4·N data bytes;
  - the loader compares it in CSUM;
  - on mismatch it enters ERROR; words already written remain written.
  - N=0 blocks carry no checksum.
- Not defined: no CSUM state; DATA returns directly to IDLE.

## Structure
- Shared package `loader_pkg`:
  - state enum;
  - command constants `CMD_IMEM`=8'h01, `CMD_DMEM`=8'h02, `CMD_RUN`=8'h03.
- One sub-module, `byte_packer`:
  - shifts bytes into a 32-bit word;
  - counts 0–3;
  - pulses `word_valid` on the 4th byte.
- The FSM, address counter and word counter live in `mem_loader`.

## Test plan
- **IMEM load and run.** Stream 01, 00000000, 0002, 20010005 44000300, then 03. Required:
  - `imem_we` at addr 0 with data 20010005;
  - `imem_we` at addr 4 with data 44000300;
  - `cpu_reset` falls the cycle after 03 and `done` = 1.
- **DMEM load with bubbles.** Stream 02, 00000010, 0001, DEADBEEF, with `in_valid` toggling every other cycle. Required: a single `dmem_we` at addr 0x10 with data DEADBEEF, and no extra strobes.
- **Bad command.** Stream 07. Required:
  - `error` = 1 the next cycle;
  - `in_ready` = 0;
  - `cpu_reset` stays 1;
  - a following 03 is ignored.
- **Range and alignment.** Start address 0x00000002 → ERROR with no writes. IMEM start at 4·IMEM_WORDS → ERROR and `imem_we` is never asserted.
- **Reset mid-word.** Issue `reset` after 2 of 4 data bytes. Required: no strobe, all outputs at reset values, and a fresh N=1 load succeeds.
- **Checksum (when enabled).** For data 01020304, checksum 04 passes and returns to IDLE; checksum 05 selects ERROR after the word write has occurred.
